// File: rtl/memgame_pkg.sv
// Shared definitions for the card-flip memory game engine: card state codes,
// FSM encoding and a width helper used to size buses from the grid geometry.
package memgame_pkg;

    localparam logic [1:0] CARD_HIDDEN  = 2'b00;
    localparam logic [1:0] CARD_FLIPPED = 2'b01;
    localparam logic [1:0] CARD_MATCHED = 2'b10;

    typedef enum logic [1:0] {
        ST_PICK1 = 2'd0,
        ST_PICK2 = 2'd1,
        ST_HOLD  = 2'd2,
        ST_WON   = 2'd3
    } state_t;

    // Bits needed to index `count` items, never less than one bit.
    function automatic int width_of(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/memgame_if.sv
// Button/deck-load inputs and display-side outputs of the memory game engine.
// master = front-end and renderer side, slave = game core.
interface memgame_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int VAL_W  = 3,
    parameter int MOVE_W = 8
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = memgame_pkg::width_of(N);
    localparam int ROW_W = memgame_pkg::width_of(ROWS);
    localparam int COL_W = memgame_pkg::width_of(COLS);
    localparam int PF_W  = memgame_pkg::width_of(N / 2 + 1);

    logic               up_btn;
    logic               down_btn;
    logic               left_btn;
    logic               right_btn;
    logic               select_btn;
    logic               new_game;
    logic               load_en;
    logic [IDX_W-1:0]   load_addr;
    logic [VAL_W-1:0]   load_val;
    logic [ROW_W-1:0]   cursor_row;
    logic [COL_W-1:0]   cursor_col;
    logic [2*N-1:0]     card_states;
    logic [VAL_W*N-1:0] card_values;
    logic [MOVE_W-1:0]  move_count;
    logic [PF_W-1:0]    pairs_found;
    logic               busy;
    logic               game_won;

    modport master (
        output up_btn, down_btn, left_btn, right_btn, select_btn, new_game,
               load_en, load_addr, load_val,
        input  cursor_row, cursor_col, card_states, card_values,
               move_count, pairs_found, busy, game_won
    );

    modport slave (
        input  up_btn, down_btn, left_btn, right_btn, select_btn, new_game,
               load_en, load_addr, load_val,
        output cursor_row, cursor_col, card_states, card_values,
               move_count, pairs_found, busy, game_won
    );

endinterface

// File: rtl/memgame_cursor_nav.sv
// Cursor row/column registers with up>down>left>right priority.
// Edges clamp unless MEMGAME_WRAP_EN is defined, in which case they wrap.
module memgame_cursor_nav
    import memgame_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      new_game,
    input  logic                      up_btn,
    input  logic                      down_btn,
    input  logic                      left_btn,
    input  logic                      right_btn,
    output logic [width_of(ROWS)-1:0] row,
    output logic [width_of(COLS)-1:0] col
);

    localparam int ROW_W = width_of(ROWS);
    localparam int COL_W = width_of(COLS);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    logic [ROW_W-1:0] row_up, row_dn;
    logic [COL_W-1:0] col_lf, col_rt;

    always_comb begin
`ifdef MEMGAME_WRAP_EN
        row_up = (row == '0)      ? ROW_MAX : row - 1'b1;
        row_dn = (row == ROW_MAX) ? '0      : row + 1'b1;
        col_lf = (col == '0)      ? COL_MAX : col - 1'b1;
        col_rt = (col == COL_MAX) ? '0      : col + 1'b1;
`else
        row_up = (row == '0)      ? row : row - 1'b1;
        row_dn = (row == ROW_MAX) ? row : row + 1'b1;
        col_lf = (col == '0)      ? col : col - 1'b1;
        col_rt = (col == COL_MAX) ? col : col + 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
        end else if (new_game) begin
            row <= '0;
            col <= '0;
        end else if (up_btn) begin
            row <= row_up;
        end else if (down_btn) begin
            row <= row_dn;
        end else if (left_btn) begin
            col <= col_lf;
        end else if (right_btn) begin
            col <= col_rt;
        end
    end

endmodule

// File: rtl/memory_game_core.sv
// Card-flip memory game engine: selection FSM, match checking, mismatch hold,
// loadable deck and counters. Edge wrapping is enabled by MEMGAME_WRAP_EN.
module memory_game_core
    import memgame_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int VAL_W    = 3,
    parameter int MOVE_W   = 8,
    parameter int HOLD_CYC = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    memgame_if.slave  bus
);

    localparam int N     = ROWS * COLS;
    localparam int PAIRS = N / 2;
    localparam int IDX_W = width_of(N);
    localparam int ROW_W = width_of(ROWS);
    localparam int COL_W = width_of(COLS);
    localparam int PF_W  = width_of(PAIRS + 1);
    localparam int HC_W  = width_of(HOLD_CYC);

    state_t            state, next_state;
    logic [1:0]        card_st  [N];
    logic [VAL_W-1:0]  card_val [N];
    logic [IDX_W-1:0]  first_idx, second_idx, cur_idx;
    logic [ROW_W-1:0]  cur_row;
    logic [COL_W-1:0]  cur_col;
    logic [HC_W-1:0]   hold_cnt;
    logic [MOVE_W-1:0] move_count;
    logic [PF_W-1:0]   pairs_found;
    logic              sel_hidden, addr_ok;
    logic              do_flip1, do_match, do_mismatch, do_hide, do_load;

    memgame_cursor_nav #(.ROWS(ROWS), .COLS(COLS)) u_nav (
        .clk       (clk),
        .reset_n   (reset_n),
        .new_game  (bus.new_game),
        .up_btn    (bus.up_btn),
        .down_btn  (bus.down_btn),
        .left_btn  (bus.left_btn),
        .right_btn (bus.right_btn),
        .row       (cur_row),
        .col       (cur_col)
    );

    // Select acts on the registered cursor, i.e. the position before any move this cycle.
    assign cur_idx    = IDX_W'(int'(cur_row) * COLS + int'(cur_col));
    assign sel_hidden = (card_st[cur_idx] == CARD_HIDDEN);
    assign addr_ok    = (int'(bus.load_addr) < N);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_PICK1;
        else          state <= next_state;
    end

    always_comb begin
        next_state  = state;
        do_flip1    = 1'b0;
        do_match    = 1'b0;
        do_mismatch = 1'b0;
        do_hide     = 1'b0;
        do_load     = 1'b0;
        case (state)
            ST_PICK1: begin
                do_load = bus.load_en && addr_ok;
                if (bus.select_btn && sel_hidden) begin
                    do_flip1   = 1'b1;
                    next_state = ST_PICK2;
                end
            end
            ST_PICK2: begin
                if (bus.select_btn && sel_hidden && (cur_idx != first_idx)) begin
                    if (card_val[cur_idx] == card_val[first_idx]) begin
                        do_match   = 1'b1;
                        next_state = (pairs_found == PF_W'(PAIRS - 1)) ? ST_WON : ST_PICK1;
                    end else begin
                        do_mismatch = 1'b1;
                        next_state  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    do_hide    = 1'b1;
                    next_state = ST_PICK1;
                end
            end
            default: ;
        endcase
        if (bus.new_game) begin
            next_state  = ST_PICK1;
            do_flip1    = 1'b0;
            do_match    = 1'b0;
            do_mismatch = 1'b0;
            do_hide     = 1'b0;
            do_load     = 1'b0;
        end
    end

    // The deck survives new_game; only reset restores the adjacent-pairs layout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                card_st[i]  <= CARD_HIDDEN;
                card_val[i] <= VAL_W'(i / 2);
            end
            first_idx   <= '0;
            second_idx  <= '0;
            hold_cnt    <= '0;
            move_count  <= '0;
            pairs_found <= '0;
        end else if (bus.new_game) begin
            for (int i = 0; i < N; i++) card_st[i] <= CARD_HIDDEN;
            hold_cnt    <= '0;
            move_count  <= '0;
            pairs_found <= '0;
        end else begin
            if (do_load) card_val[bus.load_addr] <= bus.load_val;
            if (do_flip1) begin
                card_st[cur_idx] <= CARD_FLIPPED;
                first_idx        <= cur_idx;
            end
            if (do_match || do_mismatch) begin
                if (move_count != {MOVE_W{1'b1}}) move_count <= move_count + 1'b1;
            end
            if (do_match) begin
                card_st[cur_idx]   <= CARD_MATCHED;
                card_st[first_idx] <= CARD_MATCHED;
                pairs_found        <= pairs_found + 1'b1;
            end
            if (do_mismatch) begin
                card_st[cur_idx] <= CARD_FLIPPED;
                second_idx       <= cur_idx;
                hold_cnt         <= HC_W'(HOLD_CYC - 1);
            end
            if (state == ST_HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
            if (do_hide) begin
                card_st[first_idx]  <= CARD_HIDDEN;
                card_st[second_idx] <= CARD_HIDDEN;
            end
        end
    end

    always_comb begin
        bus.card_states = '0;
        bus.card_values = '0;
        for (int i = 0; i < N; i++) begin
            bus.card_states[2*i +: 2]         = card_st[i];
            bus.card_values[VAL_W*i +: VAL_W] = card_val[i];
        end
    end

    assign bus.cursor_row  = cur_row;
    assign bus.cursor_col  = cur_col;
    assign bus.move_count  = move_count;
    assign bus.pairs_found = pairs_found;
    assign bus.busy        = (state == ST_HOLD);
    assign bus.game_won    = (state == ST_WON);

endmodule

// File: tb/tb_memory_game_core.sv
// Directed bench for memory_game_core on a 4x4 grid; a second core with a
// 2-bit move counter follows the same stimulus to exercise saturation.
module tb_memory_game_core;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int VAL_W = 3;
`ifdef MEMGAME_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    int          checks = 0;
    int          errors = 0;
    int          cur_r, cur_c;
    logic [47:0] deck_default, deck_loaded;

    memgame_if #(.ROWS(ROWS), .COLS(COLS), .VAL_W(VAL_W), .MOVE_W(8)) bus ();
    memgame_if #(.ROWS(ROWS), .COLS(COLS), .VAL_W(VAL_W), .MOVE_W(2)) bus_sat ();

    assign bus_sat.up_btn     = bus.up_btn;
    assign bus_sat.down_btn   = bus.down_btn;
    assign bus_sat.left_btn   = bus.left_btn;
    assign bus_sat.right_btn  = bus.right_btn;
    assign bus_sat.select_btn = bus.select_btn;
    assign bus_sat.new_game   = bus.new_game;
    assign bus_sat.load_en    = bus.load_en;
    assign bus_sat.load_addr  = bus.load_addr;
    assign bus_sat.load_val   = bus.load_val;

    memory_game_core #(.ROWS(ROWS), .COLS(COLS), .VAL_W(VAL_W), .MOVE_W(8), .HOLD_CYC(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    memory_game_core #(.ROWS(ROWS), .COLS(COLS), .VAL_W(VAL_W), .MOVE_W(2), .HOLD_CYC(16)) dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_sat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic up, input logic down, input logic left,
                                 input logic right, input logic sel, input logic ng);
        bus.up_btn     = up;
        bus.down_btn   = down;
        bus.left_btn   = left;
        bus.right_btn  = right;
        bus.select_btn = sel;
        bus.new_game   = ng;
        @(posedge clk);
        #1;
        bus.up_btn     = 1'b0;
        bus.down_btn   = 1'b0;
        bus.left_btn   = 1'b0;
        bus.right_btn  = 1'b0;
        bus.select_btn = 1'b0;
        bus.new_game   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic loadCard(input int addr, input int val);
        bus.load_en   = 1'b1;
        bus.load_addr = 4'(addr);
        bus.load_val  = 3'(val);
        @(posedge clk);
        #1;
        bus.load_en   = 1'b0;
    endtask

    // Interior moves only, so the cursor model holds for both edge modes.
    task automatic moveTo(input int r, input int c);
        while (cur_r < r) begin applyStimulus(0, 1, 0, 0, 0, 0); cur_r++; end
        while (cur_r > r) begin applyStimulus(1, 0, 0, 0, 0, 0); cur_r--; end
        while (cur_c < c) begin applyStimulus(0, 0, 0, 1, 0, 0); cur_c++; end
        while (cur_c > c) begin applyStimulus(0, 0, 1, 0, 0, 0); cur_c--; end
    endtask

    task automatic selectCard(input int idx);
        moveTo(idx / COLS, idx % COLS);
        applyStimulus(0, 0, 0, 0, 1, 0);
    endtask

    task automatic newGame();
        applyStimulus(0, 0, 0, 0, 0, 1);
        cur_r = 0;
        cur_c = 0;
    endtask

    task automatic checkCursor(input string tag, input int r, input int c);
        checkOutput({tag, "_row"}, 64'(bus.cursor_row), 64'(r));
        checkOutput({tag, "_col"}, 64'(bus.cursor_col), 64'(c));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.up_btn = 0; bus.down_btn = 0; bus.left_btn = 0; bus.right_btn = 0;
        bus.select_btn = 0; bus.new_game = 0; bus.load_en = 0;
        bus.load_addr = '0; bus.load_val = '0;
        reset_n = 1'b0;
        cur_r = 0;
        cur_c = 0;
        for (int i = 0; i < 16; i++) deck_default[3*i +: 3] = 3'(i / 2);
        deck_loaded = deck_default;
        deck_loaded[15 +: 3] = 3'd7;
        deck_loaded[27 +: 3] = 3'd7;

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);

        checkCursor("rst", 0, 0);
        checkOutput("rst_states", 64'(bus.card_states), 64'h0);
        checkOutput("rst_values", 64'(bus.card_values), 64'(deck_default));
        checkOutput("rst_moves", 64'(bus.move_count), 64'd0);
        checkOutput("rst_pairs", 64'(bus.pairs_found), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_won", 64'(bus.game_won), 64'd0);

        selectCard(0);
        checkOutput("flip_first", 64'(bus.card_states), 64'h1);
        selectCard(1);
        checkOutput("match_states", 64'(bus.card_states), 64'hA);
        checkOutput("match_pairs", 64'(bus.pairs_found), 64'd1);
        checkOutput("match_moves", 64'(bus.move_count), 64'd1);

        selectCard(2);
        selectCard(4);
        checkOutput("mis_states", 64'(bus.card_states), 64'h11A);
        checkOutput("mis_busy", 64'(bus.busy), 64'd1);
        checkOutput("mis_moves", 64'(bus.move_count), 64'd2);
        applyStimulus(0, 0, 0, 1, 0, 0);
        cur_c++;
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("hold_select", 64'(bus.card_states), 64'h11A);
        idle(13);
        checkOutput("hold_last_busy", 64'(bus.busy), 64'd1);
        checkOutput("hold_last_states", 64'(bus.card_states), 64'h11A);
        idle(1);
        checkOutput("hold_end_busy", 64'(bus.busy), 64'd0);
        checkOutput("hold_end_states", 64'(bus.card_states), 64'hA);
        checkOutput("hold_end_moves", 64'(bus.move_count), 64'd2);

        for (int p = 1; p < 8; p++) begin
            selectCard(2 * p);
            selectCard(2 * p + 1);
            if (p == 6) begin
                checkOutput("pre_win_won", 64'(bus.game_won), 64'd0);
                checkOutput("pre_win_pairs", 64'(bus.pairs_found), 64'd7);
            end
        end
        checkOutput("win_won", 64'(bus.game_won), 64'd1);
        checkOutput("win_pairs", 64'(bus.pairs_found), 64'd8);
        checkOutput("win_moves", 64'(bus.move_count), 64'd9);
        checkOutput("win_states", 64'(bus.card_states), 64'hAAAA_AAAA);
        checkOutput("sat_moves", 64'(bus_sat.move_count), 64'd3);

        applyStimulus(0, 0, 0, 0, 1, 0);
        loadCard(0, 5);
        checkOutput("won_moves", 64'(bus.move_count), 64'd9);
        checkOutput("won_load", 64'(bus.card_values), 64'(deck_default));

        newGame();
        checkOutput("ng_states", 64'(bus.card_states), 64'h0);
        checkOutput("ng_won", 64'(bus.game_won), 64'd0);
        checkOutput("ng_pairs", 64'(bus.pairs_found), 64'd0);
        checkOutput("ng_moves", 64'(bus.move_count), 64'd0);
        checkOutput("ng_values", 64'(bus.card_values), 64'(deck_default));
        checkCursor("ng", 0, 0);

        loadCard(5, 7);
        loadCard(9, 7);
        checkOutput("load_values", 64'(bus.card_values), 64'(deck_loaded));
        selectCard(5);
        selectCard(9);
        checkOutput("load_match", 64'(bus.card_states), 64'h80800);
        checkOutput("load_pairs", 64'(bus.pairs_found), 64'd1);
        selectCard(0);
        loadCard(0, 5);
        checkOutput("pick2_load", 64'(bus.card_values), 64'(deck_loaded));
        selectCard(1);
        checkOutput("pick2_match", 64'(bus.card_states), 64'h8080A);
        checkOutput("pick2_moves", 64'(bus.move_count), 64'd2);

        moveTo(0, 2);
        applyStimulus(0, 0, 0, 0, 1, 1);
        cur_r = 0;
        cur_c = 0;
        checkOutput("ng_sel_states", 64'(bus.card_states), 64'h0);
        checkCursor("ng_sel", 0, 0);

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkCursor("edge_up", WRAP ? 3 : 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkCursor("edge_left", WRAP ? 3 : 0, WRAP ? 3 : 0);
        newGame();
        moveTo(1, 1);
        applyStimulus(1, 0, 0, 1, 0, 0);
        cur_r = 0;
        checkCursor("prio_up_right", 0, 1);
        moveTo(3, 3);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkCursor("edge_down", WRAP ? 0 : 3, 3);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkCursor("edge_right", WRAP ? 0 : 3, WRAP ? 0 : 3);
        newGame();

        selectCard(0);
        selectCard(2);
        idle(3);
        checkOutput("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("async_rst_states", 64'(bus.card_states), 64'h0);
        checkOutput("async_rst_moves", 64'(bus.move_count), 64'd0);
        checkOutput("async_rst_values", 64'(bus.card_values), 64'(deck_default));
        checkCursor("async_rst", 0, 0);
        #2;
        reset_n = 1'b1;
        cur_r = 0;
        cur_c = 0;
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
